// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch path: PC select codes, controller states
// and the PC reset vector.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_JR    = 2'b00,
    PC_BRJMP = 2'b01,
    PC_PLUS4 = 2'b10
  } pc_sel_e;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_DRAIN,
    ST_HALT
  } fetch_state_e;

  localparam logic [31:0] PC_RESET = 32'hFFFF_FFFC;

  // Only 2'b01 selects the branch/jal target; every other code is a jalr.
  function automatic pc_sel_e redir_sel(input logic [1:0] kind);
    return (kind == 2'b01) ? PC_BRJMP : PC_JR;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Handshake between the fetch controller and the imem/execute/PC side.
interface fetch_ctrl_if;
  logic       imem_req_ready;
  logic       imem_resp_valid;
  logic       redir_valid;
  logic [1:0] redir_kind;
  logic       halt_req;
  logic [1:0] pc_sel;
  logic       pc_stall;
  logic       imem_req_valid;
  logic       if_valid;
  logic       if_kill;

  modport master (
    input  imem_req_ready, imem_resp_valid, redir_valid, redir_kind, halt_req,
    output pc_sel, pc_stall, imem_req_valid, if_valid, if_kill
  );

  modport slave (
    output imem_req_ready, imem_resp_valid, redir_valid, redir_kind, halt_req,
    input  pc_sel, pc_stall, imem_req_valid, if_valid, if_kill
  );
endinterface

// File: rtl/fetch_ctrl_pc_gen.sv
// Program counter register; writes only when the fetch controller releases it.
module pc_gen
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] brjmp_target,
  input  logic [31:0] jump_reg_target,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (reset)
      pc <= PC_RESET;
    else if (we) begin
      case (pc_sel_e'(pc_sel))
        PC_PLUS4: pc <= pc + 32'd4;
        PC_BRJMP: pc <= brjmp_target;
        default:  pc <= jump_reg_target;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one imem request in flight, redirect squash
// with drain of a wrong-path response, sticky halt and a stall-cycle counter.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  fetch_ctrl_if.master     bus,
  output logic [CNT_W-1:0] stall_cnt
);

  fetch_state_e state, state_nx;
  pc_sel_e      sel_c;
  logic         stall_c, reqv_c, ifv_c, kill_c;
  logic         redir_live;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_BOOT;
    else
      state <= state_nx;
  end

  assign redir_live = bus.redir_valid &&
                      (state inside {ST_REQ, ST_WAIT, ST_DRAIN});

  always_comb begin
    state_nx = state;
    sel_c    = PC_PLUS4;
    stall_c  = 1'b1;
    reqv_c   = 1'b0;
    ifv_c    = 1'b0;
    kill_c   = 1'b0;
    case (state)
      ST_BOOT: begin
        stall_c  = 1'b0;
        state_nx = ST_REQ;
      end
      ST_REQ: begin
        // A redirect still issues; an accepted request must then be drained.
        if (bus.redir_valid) begin
          reqv_c = 1'b1;
          if (bus.imem_req_ready) state_nx = ST_DRAIN;
        end else if (bus.halt_req) begin
          state_nx = ST_HALT;
        end else begin
          reqv_c = 1'b1;
          if (bus.imem_req_ready) state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.redir_valid) begin
          state_nx = bus.imem_resp_valid ? ST_REQ : ST_DRAIN;
        end else if (bus.imem_resp_valid) begin
          ifv_c    = 1'b1;
          stall_c  = 1'b0;
          state_nx = bus.halt_req ? ST_HALT : ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (bus.imem_resp_valid)
          state_nx = (bus.halt_req && !bus.redir_valid) ? ST_HALT : ST_REQ;
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_BOOT;
    endcase

    // Redirect outputs override whatever the state decoded above.
    if (redir_live) begin
      sel_c   = redir_sel(bus.redir_kind);
      stall_c = 1'b0;
      kill_c  = 1'b1;
    end

    if (reset) begin
      sel_c   = PC_PLUS4;
      stall_c = 1'b1;
      reqv_c  = 1'b0;
      ifv_c   = 1'b0;
      kill_c  = 1'b0;
    end
  end

  assign bus.pc_sel         = sel_c;
  assign bus.pc_stall       = stall_c;
  assign bus.imem_req_valid = reqv_c;
  assign bus.if_valid       = ifv_c;
  assign bus.if_kill        = kill_c;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   ((state == ST_WAIT) || (state == ST_DRAIN)),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vectors for fetch_ctrl driving a pc_gen, one row per clock cycle.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  typedef struct {
    string       nm;
    logic        rst, rdy, rsp, rdr;
    logic [1:0]  kind;
    logic        hlt;
    logic [1:0]  sel;
    logic        stl, rqv, ifv, kil;
    logic [31:0] pc;
    logic [3:0]  cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  stall_cnt;
  logic [31:0] pc;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  fetch_ctrl_if bus();

  fetch_ctrl #(.CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  pc_gen u_pc (
    .clk             (clk),
    .reset           (reset),
    .we              (~bus.pc_stall),
    .pc_sel          (bus.pc_sel),
    .brjmp_target    (32'h0000_0100),
    .jump_reg_target (32'h0000_0040),
    .pc              (pc)
  );

  function automatic vec_t mk(string nm, logic rst, logic rdy, logic rsp,
                              logic rdr, logic [1:0] kind, logic hlt,
                              logic [1:0] sel, logic stl, logic rqv,
                              logic ifv, logic kil, logic [31:0] pcv,
                              logic [3:0] cnt);
    vec_t v;
    v.nm = nm; v.rst = rst; v.rdy = rdy; v.rsp = rsp; v.rdr = rdr;
    v.kind = kind; v.hlt = hlt; v.sel = sel; v.stl = stl; v.rqv = rqv;
    v.ifv = ifv; v.kil = kil; v.pc = pcv; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string nm, string fld, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got %h want %h", nm, fld, got, want);
    end
  endtask

  task automatic step(vec_t v);
    @(negedge clk);
    reset               = v.rst;
    bus.imem_req_ready  = v.rdy;
    bus.imem_resp_valid = v.rsp;
    bus.redir_valid     = v.rdr;
    bus.redir_kind      = v.kind;
    bus.halt_req        = v.hlt;
    #2;
    chk(v.nm, "pc_sel",         32'(bus.pc_sel),   32'(v.sel));
    chk(v.nm, "pc_stall",       32'(bus.pc_stall), 32'(v.stl));
    chk(v.nm, "imem_req_valid", 32'(bus.imem_req_valid), 32'(v.rqv));
    chk(v.nm, "if_valid",       32'(bus.if_valid), 32'(v.ifv));
    chk(v.nm, "if_kill",        32'(bus.if_kill),  32'(v.kil));
    chk(v.nm, "pc",             pc,                v.pc);
    chk(v.nm, "stall_cnt",      32'(stall_cnt),    32'(v.cnt));
  endtask

  initial begin
    reset = 1'b1;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
    bus.redir_valid = 1'b0; bus.redir_kind = 2'b00; bus.halt_req = 1'b0;
    repeat (2) @(posedge clk);

    //              name       rst rdy rsp rdr kind  hlt  sel   stl rqv ifv kil pc            cnt
    tbl.push_back(mk("rst",     1, 0, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'hFFFF_FFFC, 4'd0));
    tbl.push_back(mk("boot",    0, 1, 0, 0, 2'b00, 0, 2'b10, 0, 0, 0, 0, 32'hFFFF_FFFC, 4'd0));
    tbl.push_back(mk("req0",    0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 1, 0, 0, 32'h0,  4'd0));
    tbl.push_back(mk("rsp0",    0, 1, 1, 0, 2'b00, 0, 2'b10, 0, 0, 1, 0, 32'h0,  4'd0));
    tbl.push_back(mk("req4",    0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 1, 0, 0, 32'h4,  4'd1));
    tbl.push_back(mk("rsp4",    0, 1, 1, 0, 2'b00, 0, 2'b10, 0, 0, 1, 0, 32'h4,  4'd1));
    tbl.push_back(mk("req8",    0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 1, 0, 0, 32'h8,  4'd2));
    tbl.push_back(mk("lat1",    0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'h8,  4'd2));
    tbl.push_back(mk("lat2",    0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'h8,  4'd3));
    tbl.push_back(mk("lat3",    0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'h8,  4'd4));
    tbl.push_back(mk("lat4",    0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'h8,  4'd5));
    tbl.push_back(mk("lat_rsp", 0, 1, 1, 0, 2'b00, 0, 2'b10, 0, 0, 1, 0, 32'h8,  4'd6));
    tbl.push_back(mk("req_nrdy",0, 0, 0, 0, 2'b00, 0, 2'b10, 1, 1, 0, 0, 32'hC,  4'd7));
    tbl.push_back(mk("req_c",   0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 1, 0, 0, 32'hC,  4'd7));
    tbl.push_back(mk("wait_rdr",0, 1, 0, 1, 2'b01, 0, 2'b01, 0, 0, 0, 1, 32'hC,  4'd7));
    tbl.push_back(mk("drain1",  0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'h100, 4'd8));
    tbl.push_back(mk("drain_rs",0, 1, 1, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'h100, 4'd9));
    tbl.push_back(mk("req100",  0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 1, 0, 0, 32'h100, 4'd10));
    tbl.push_back(mk("rdr_rsp", 0, 1, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0, 1, 32'h100, 4'd10));
    tbl.push_back(mk("kind10",  0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 1, 0, 1, 32'h40, 4'd11));
    tbl.push_back(mk("req_rdr", 0, 1, 0, 1, 2'b01, 0, 2'b01, 0, 1, 0, 1, 32'h40, 4'd11));
    tbl.push_back(mk("drn_rdr", 0, 1, 0, 1, 2'b11, 0, 2'b00, 0, 0, 0, 1, 32'h100, 4'd11));
    tbl.push_back(mk("drn_rr",  0, 1, 1, 1, 2'b01, 0, 2'b01, 0, 0, 0, 1, 32'h40, 4'd12));
    tbl.push_back(mk("hlt_rdr", 0, 0, 0, 1, 2'b00, 1, 2'b00, 0, 1, 0, 1, 32'h100, 4'd13));
    tbl.push_back(mk("hlt_req", 0, 1, 0, 0, 2'b00, 1, 2'b10, 1, 0, 0, 0, 32'h40, 4'd13));
    tbl.push_back(mk("halt_rd", 0, 1, 1, 1, 2'b01, 1, 2'b10, 1, 0, 0, 0, 32'h40, 4'd13));
    tbl.push_back(mk("halt2",   0, 1, 0, 0, 2'b00, 1, 2'b10, 1, 0, 0, 0, 32'h40, 4'd13));
    tbl.push_back(mk("rst_h",   1, 1, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'h40, 4'd13));
    tbl.push_back(mk("boot2",   0, 1, 0, 0, 2'b00, 0, 2'b10, 0, 0, 0, 0, 32'hFFFF_FFFC, 4'd0));
    tbl.push_back(mk("req2",    0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 1, 0, 0, 32'h0,  4'd0));
    tbl.push_back(mk("w_hlt",   0, 1, 0, 0, 2'b00, 1, 2'b10, 1, 0, 0, 0, 32'h0,  4'd0));
    tbl.push_back(mk("w_hlt_rs",0, 1, 1, 0, 2'b00, 1, 2'b10, 0, 0, 1, 0, 32'h0,  4'd1));
    tbl.push_back(mk("halt_w",  0, 1, 0, 0, 2'b00, 1, 2'b10, 1, 0, 0, 0, 32'h4,  4'd2));
    tbl.push_back(mk("rst_h2",  1, 0, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'h4,  4'd2));
    tbl.push_back(mk("boot3",   0, 1, 0, 0, 2'b00, 0, 2'b10, 0, 0, 0, 0, 32'hFFFF_FFFC, 4'd0));
    tbl.push_back(mk("req_rd3", 0, 1, 0, 1, 2'b01, 0, 2'b01, 0, 1, 0, 1, 32'h0,  4'd0));
    tbl.push_back(mk("d_hlt_rs",0, 1, 1, 0, 2'b00, 1, 2'b10, 1, 0, 0, 0, 32'h100, 4'd0));
    tbl.push_back(mk("halt_d",  0, 1, 0, 0, 2'b00, 1, 2'b10, 1, 0, 0, 0, 32'h100, 4'd1));
    tbl.push_back(mk("rst_h3",  1, 0, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'h100, 4'd1));
    tbl.push_back(mk("boot4",   0, 1, 0, 0, 2'b00, 0, 2'b10, 0, 0, 0, 0, 32'hFFFF_FFFC, 4'd0));
    tbl.push_back(mk("req4s",   0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 1, 0, 0, 32'h0,  4'd0));

    foreach (tbl[i]) step(tbl[i]);

    // Long memory stall: the 4-bit counter must stop at 15.
    for (int i = 0; i < 20; i++)
      step(mk("sat", 0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'h0,
              (i > 15) ? 4'd15 : 4'(i)));

    // Reset in the middle of WAIT abandons the request; a stray response
    // arriving in BOOT must not be forwarded.
    step(mk("rst_wait", 1, 1, 1, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 32'h0, 4'd15));
    step(mk("boot5",    0, 1, 1, 0, 2'b00, 0, 2'b10, 0, 0, 0, 0, 32'hFFFF_FFFC, 4'd0));
    step(mk("req5",     0, 1, 0, 0, 2'b00, 0, 2'b10, 1, 1, 0, 0, 32'h0, 4'd0));
    step(mk("rsp5",     0, 1, 1, 0, 2'b00, 0, 2'b10, 0, 0, 1, 0, 32'h0, 4'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall-cycle counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req_ready  input  1  instruction memory accepts a request this cycle.
REQ-005 imem_resp_valid  input  1  instruction word for the outstanding request returns this cycle.
REQ-006 redir_valid  input  1  execute stage resolved a taken control transfer this cycle.
REQ-007 redir_kind  input  2  PC select code for the redirect: 2'b01 is the branch/jal target, 2'b00 is the jalr target; other codes are illegal.
REQ-008 halt_req  input  1  request to stop fetching, sticky until reset.
REQ-009 pc_sel  output  2  PC mux select: 2'b10 is PC+4, 2'b01 is brjmp_target, 2'b00 is jump_reg_target.
REQ-010 pc_stall  output  1  PC register holds its value when high.
REQ-011 imem_req_valid  output  1  fetch request at the current PC.
REQ-012 if_valid  output  1  returned instruction is valid for decode.
REQ-013 if_kill  output  1  decode/fetch stage content is squashed this cycle.
REQ-014 stall_cnt  output  CNT_W  number of cycles spent in WAIT or DRAIN.

Function
REQ-015 The controller SHALL implement the states BOOT, REQ, WAIT, DRAIN and HALT, with at most one imem request outstanding.
REQ-016 BOOT SHALL last one cycle with pc_sel=10 and pc_stall=0, so the PC steps from 0xFFFFFFFC to 0x00000000; the next state is REQ.
REQ-017 REQ SHALL drive imem_req_valid=1 and pc_stall=1; on imem_req_ready with no redirect, the next state is WAIT.
REQ-018 WAIT SHALL drive pc_stall=1 and increment stall_cnt; on imem_resp_valid with no redirect, it SHALL drive if_valid=1, pc_sel=10 and pc_stall=0, and the next state is REQ.
REQ-019 On any redirect the controller SHALL drive pc_sel=redir_kind, pc_stall=0 and if_kill=1 for one cycle.
REQ-020 Redirect next states:
- Redirect in REQ without imem_req_ready: stay in REQ.
- Redirect in REQ with imem_req_ready: go to DRAIN; the issued wrong-path request is counted as outstanding.
- Redirect in WAIT without imem_resp_valid: go to DRAIN.
- Redirect in WAIT with imem_resp_valid: the response is dropped (if_valid=0) and the next state is REQ.
REQ-021 DRAIN SHALL drive pc_stall=1, imem_req_valid=0 and if_valid=0, and SHALL increment stall_cnt; on imem_resp_valid the response is discarded and the next state is REQ.
REQ-022 A redirect in DRAIN SHALL load the new target, and the state SHALL stay DRAIN unless imem_resp_valid is high that cycle, in which case the next state is REQ.
REQ-023 Redirect SHALL take priority over halt, and halt SHALL take priority over issuing a request.
REQ-024 halt_req in REQ without a redirect SHALL suppress imem_req_valid and move to HALT.
REQ-025 halt_req in WAIT SHALL take effect when the response completes, and halt_req in DRAIN SHALL take effect when the drain completes.
REQ-026 HALT SHALL drive pc_stall=1 and keep all other outputs low, and it SHALL ignore redirects until reset.
REQ-027 When pc_stall=1, pc_sel SHALL be 2'b10.
REQ-028 stall_cnt SHALL saturate at all-ones and never wrap.
REQ-029 A redir_kind value of 2'b10 or 2'b11 SHALL be treated as 2'b00.
REQ-030 All outputs except stall_cnt SHALL be combinational decodes of state and inputs, and stall_cnt SHALL be registered.

Reset
REQ-031 reset SHALL force the state to BOOT and stall_cnt to 0.
REQ-032 While reset is high, outputs SHALL be pc_sel=10, pc_stall=1, imem_req_valid=0, if_valid=0 and if_kill=0.
REQ-033 Reset asserted mid-operation SHALL abandon any outstanding request, with no drain.

Structure
REQ-034 The PC select codes (2'b10, 2'b01, 2'b00) and the state encoding SHALL live in a shared package that both the PC generator and fetch_ctrl use.
REQ-035 The PC generator SHALL gain a write enable driven by ~pc_stall, with its reset value -4 unchanged.
REQ-036 One sub-module, sat_counter (parameter W, inputs inc and clr), SHALL implement stall_cnt.

Verification
REQ-037 Boot: release reset, ready=1, each response one cycle after its request -> the PC sequence is 0xFFFFFFFC, 0, 4, 8, with if_valid every second cycle.
REQ-038 Memory latency: ready=1 and response 5 cycles late -> pc_stall is held for 5 cycles and stall_cnt increments by 5 per fetch.
REQ-039 Redirect in WAIT: redir_valid with kind=01 and brjmp_target=0x100 -> DRAIN; the late response is dropped with if_valid=0, then a fetch is issued at 0x100.
REQ-040 Simultaneous redirect and response in WAIT: kind=00 and jump_reg_target=0x40 -> if_valid=0, if_kill=1, next fetch at 0x40 with no drain.
REQ-041 Halt: halt_req in REQ together with redir_valid -> the redirect is taken, then HALT is entered on the next REQ cycle, and imem_req_valid stays 0 until reset.
REQ-042 Saturation and reset: CNT_W=4 with a 20-cycle wait -> stall_cnt reads 15; asserting reset mid-WAIT -> stall_cnt=0 and BOOT restarts the PC at 0.
